serial_adder: RTL and testbench

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/serial_adder.sv | 88 ++++++++
 tb/tb_serial_adder.sv | 135 +++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial add/subtract unit, one full-adder slice, LSB first
// Operands shift right each RUN cycle; result bits enter the result register from the top.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             cin,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf,
  output logic             busy,
  output logic             done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] a, b, res;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             accept, last, sum, carry_nx;

  assign accept   = start && ((state == IDLE) || (state == DONE));
  assign last     = (cnt == CW'(WIDTH - 1));
  assign sum      = a[0] ^ b[0] ^ carry;
  assign carry_nx = (a[0] & b[0]) | (a[0] & carry) | (b[0] & carry);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE: if (start) state_nx = RUN;
      RUN: begin
        busy = 1'b1;
        if (last) state_nx = DONE;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = start ? RUN : IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Subtraction is x + ~y + 1, so the carry register doubles as the borrow-in.
  always_ff @(posedge clk) begin
    if (rst) begin
      a     <= '0;
      b     <= '0;
      res   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      s     <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else if (accept) begin
      a     <= x;
      b     <= sub ? ~y : y;
      carry <= sub ? 1'b1 : cin;
      cnt   <= '0;
    end else if (state == RUN) begin
      a     <= a >> 1;
      b     <= b >> 1;
      carry <= carry_nx;
      res   <= {sum, res[WIDTH-1:1]};
      cnt   <= cnt + CW'(1);
      if (last) begin
        s    <= {sum, res[WIDTH-1:1]};
        cout <= carry_nx;
        ovf  <= carry ^ carry_nx;
      end
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - scoreboard bench for serial_adder with directed vectors
// Expected {s,cout,ovf} are queued at issue; a monitor pops them on every done pulse.
module tb_serial_adder;

  logic       clk, rst, start, sub, cin;
  logic [7:0] x, y, s;
  logic       cout, ovf, busy, done;

  int checks = 0;
  int errors = 0;
  logic [9:0] exp_q[$];
  logic [7:0] last_s = 8'h00;

  serial_adder #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .sub(sub), .x(x), .y(y), .cin(cin),
    .s(s), .cout(cout), .ovf(ovf), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && done) begin
      if (exp_q.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
      else chk("result", {22'd0, s, cout, ovf}, {22'd0, exp_q.pop_front()});
    end
  end

  task automatic issue(input logic [7:0] xi, input logic [7:0] yi, input logic ci,
                       input logic sbi, input logic [9:0] e, input bit push);
    @(posedge clk); #1;
    x = xi; y = yi; cin = ci; sub = sbi; start = 1'b1;
    if (push) exp_q.push_back(e);
  endtask

  // Called in the start cycle; counts cycles until done and checks latency, busy and hold.
  task automatic wait_done(input logic [7:0] es, input int poke, input bit chain,
                           input logic [7:0] nx, input logic [7:0] ny,
                           input logic nsub, input logic [9:0] nexp);
    int lat = 0;
    int bcnt = 0;
    bit got = 0;
    bit hold_bad = 0;
    for (int n = 1; n <= 20 && !got; n++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (n == poke) begin
        start = 1'b1; x = 8'h11; y = 8'h22; sub = 1'b0; cin = 1'b0;
      end
      if (chain && n == 9) begin
        start = 1'b1; x = nx; y = ny; sub = nsub; cin = 1'b0;
        exp_q.push_back(nexp);
      end
      @(negedge clk);
      if (busy) bcnt++;
      if (done) begin
        got = 1;
        lat = n;
      end else if (s !== last_s) hold_bad = 1;
    end
    if (!got) $display("FAIL timeout: got no done expected done within 20 cycles");
    chk("latency", lat, 9);
    chk("busy_cycles", bcnt, 8);
    chk("hold_s", {31'd0, hold_bad}, 32'd0);
    last_s = es;
  endtask

  task automatic op(input logic [7:0] xi, input logic [7:0] yi, input logic ci,
                    input logic sbi, input logic [9:0] e, input int poke);
    issue(xi, yi, ci, sbi, e, 1'b1);
    wait_done(e[9:2], poke, 1'b0, 8'h00, 8'h00, 1'b0, 10'h000);
  endtask

  initial begin
    bit seen;
    rst = 1'b1; start = 1'b1; sub = 1'b0; cin = 1'b0; x = 8'hAA; y = 8'h55;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_s", {24'd0, s}, 32'h0);
    chk("rst_cout", {31'd0, cout}, 32'd0);
    chk("rst_ovf", {31'd0, ovf}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("rst_start_ignored", {31'd0, busy}, 32'd0);

    op(8'h3C, 8'h15, 1'b1, 1'b0, {8'h52, 1'b0, 1'b0}, 0);
    op(8'hFF, 8'h01, 1'b0, 1'b0, {8'h00, 1'b1, 1'b0}, 0);
    op(8'h7F, 8'h01, 1'b0, 1'b0, {8'h80, 1'b0, 1'b1}, 0);
    op(8'h05, 8'h07, 1'b1, 1'b1, {8'hFE, 1'b0, 1'b0}, 0);
    op(8'h80, 8'h01, 1'b0, 1'b1, {8'h7F, 1'b1, 1'b1}, 0);
    op(8'h0A, 8'h0B, 1'b0, 1'b0, {8'h15, 1'b0, 1'b0}, 3);

    issue(8'h40, 8'h40, 1'b0, 1'b0, {8'h80, 1'b0, 1'b1}, 1'b1);
    wait_done(8'h80, 0, 1'b1, 8'h10, 8'h20, 1'b1, {8'hF0, 1'b0, 1'b0});
    wait_done(8'hF0, 0, 1'b0, 8'h00, 8'h00, 1'b0, 10'h000);

    issue(8'h3C, 8'h15, 1'b1, 1'b0, 10'h000, 1'b0);
    for (int n = 1; n <= 4; n++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (n == 4) rst = 1'b1;
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_s", {24'd0, s}, 32'h0);
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    chk("abort_no_done", {31'd0, seen}, 32'd0);
    last_s = 8'h00;
    op(8'h01, 8'h02, 1'b1, 1'b0, {8'h04, 1'b0, 1'b0}, 0);

    repeat (3) @(negedge clk);
    chk("queue_empty", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
